// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer covering hazards forwarding cannot resolve: load-use,
// branch operands not ready in ID, and HI/LO access while the mul/div unit is busy.
//
// state | meaning
// IDLE  | mul/div unit free, HI/LO readable
// BUSY  | mult/div in flight, cnt holds remaining cycles
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  Opcode_IFID,
    input  logic [5:0]  Funct_IFID,
    input  logic [4:0]  RsAddr_IFID,
    input  logic [4:0]  RtAddr_IFID,
    input  logic [4:0]  RdAddr_IDEX,
    input  logic        RegWrite_IDEX,
    input  logic        MemRead_IDEX,
    input  logic [4:0]  RdAddr_EXMEM,
    input  logic        MemRead_EXMEM,
    input  logic        BranchTaken,
    input  logic        Jump_ID,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXFlush,
    output logic        IFIDFlush,
    output logic        MulDivStart,
    output logic        MulDivBusy,
    output logic        MulDivDone,
    output logic [15:0] StallCount
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MulLatC = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DivLatC = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             startNext, doneNext;

    logic usesRs, usesRt, isBr1, isBr2, isHiLo, isMulDiv;
    logic rsLive, rtLive, cmpRs, cmpRt;
    logic loadUse, branchStall, hiLoStall, stall;

    always_comb begin
        usesRs   = !((Opcode_IFID == 6'h02) || (Opcode_IFID == 6'h03));
        usesRt   = Opcode_IFID inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
        isBr2    = Opcode_IFID inside {6'h04, 6'h05};
        isBr1    = Opcode_IFID inside {6'h01, 6'h06, 6'h07};
        isHiLo   = (Opcode_IFID == 6'h00) && (Funct_IFID inside {[6'h10:6'h13], [6'h18:6'h1B]});
        isMulDiv = (Opcode_IFID == 6'h00) && (Funct_IFID inside {[6'h18:6'h1B]});
        rsLive   = usesRs && (RsAddr_IFID != 5'd0);
        rtLive   = usesRt && (RtAddr_IFID != 5'd0);
        cmpRs    = (isBr1 || isBr2) && (RsAddr_IFID != 5'd0);
        cmpRt    = isBr2 && (RtAddr_IFID != 5'd0);
    end

    always_comb begin
        loadUse = MemRead_IDEX && (RdAddr_IDEX != 5'd0) &&
                  ((rsLive && (RsAddr_IFID == RdAddr_IDEX)) ||
                   (rtLive && (RtAddr_IFID == RdAddr_IDEX)));
        // ALU result in EX or load in MEM is too late for the compare in ID
        branchStall = (RegWrite_IDEX && (RdAddr_IDEX != 5'd0) &&
                       ((cmpRs && (RsAddr_IFID == RdAddr_IDEX)) ||
                        (cmpRt && (RtAddr_IFID == RdAddr_IDEX)))) ||
                      (MemRead_EXMEM && (RdAddr_EXMEM != 5'd0) &&
                       ((cmpRs && (RsAddr_IFID == RdAddr_EXMEM)) ||
                        (cmpRt && (RtAddr_IFID == RdAddr_EXMEM))));
        hiLoStall = (state == BUSY) && isHiLo;
        stall     = loadUse || branchStall || hiLoStall;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            MulDivStart <= 1'b0;
            MulDivDone  <= 1'b0;
            StallCount  <= 16'd0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            MulDivStart <= startNext;
            MulDivDone  <= doneNext;
            if (stall && (StallCount != 16'hFFFF)) begin
                StallCount <= StallCount + 16'd1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        startNext = 1'b0;
        doneNext  = 1'b0;
        case (state)
            IDLE: begin
                if (isMulDiv && !stall) begin
                    stateNext = BUSY;
                    cntNext   = Funct_IFID[1] ? DivLatC : MulLatC;
                    startNext = 1'b1;
                end
            end
            BUSY: begin
                cntNext = cnt - CntOne;
                if (cnt == CntOne) begin
                    stateNext = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Stall wins over flush: a branch resolved on stale operands is discarded
    always_comb begin
        MulDivBusy = (state == BUSY);
        if (!rst_n) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            IFIDFlush = 1'b1;
        end else if (stall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
            IFIDFlush = 1'b0;
        end else begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            IDEXFlush = 1'b0;
            IFIDFlush = BranchTaken || Jump_ID;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Stall/flush sequencer for the 5-stage MIPS pipeline. It sits beside the forwarding logic and covers the hazards forwarding cannot resolve: load-use, branch-compare operands not yet available in ID, and HI/LO access while the multi-cycle mul/div unit is busy. It drives PC/IFID write enables and IDEX/IFID flushes, sequences the mul/div unit with a latency counter, and keeps a saturating stall-cycle counter.

Parameters:
MUL_LAT, 4, cycles mult/multu occupies the mul/div unit (1..2^CNT_W-1)
DIV_LAT, 32, cycles div/divu occupies the mul/div unit (1..2^CNT_W-1)
CNT_W, 6, width of the mul/div latency counter

Ports:
clk  in  1  pipeline clock
rst_n  in  1  synchronous reset, active low
Opcode_IFID  in  6  opcode of instruction in ID
Funct_IFID  in  6  funct field of instruction in ID
RsAddr_IFID  in  5  rs of instruction in ID
RtAddr_IFID  in  5  rt of instruction in ID
RdAddr_IDEX  in  5  destination register of instruction in EX
RegWrite_IDEX  in  1  instruction in EX writes a register
MemRead_IDEX  in  1  instruction in EX is a load
RdAddr_EXMEM  in  5  destination register of instruction in MEM
MemRead_EXMEM  in  1  instruction in MEM is a load
BranchTaken  in  1  branch in ID resolved taken
Jump_ID  in  1  j/jal/jr in ID
PCWrite  out  1  PC write enable
IFIDWrite  out  1  IF/ID write enable
IDEXFlush  out  1  insert bubble into ID/EX
IFIDFlush  out  1  squash instruction in IF/ID
MulDivStart  out  1  one-cycle pulse: mul/div op is in EX
MulDivBusy  out  1  mul/div unit occupied
MulDivDone  out  1  one-cycle pulse: result ready in HI/LO
StallCount  out  16  saturating count of stall cycles

Behaviour:
- Usage decode (ID): UsesRs = opcode not 0x02/0x03. UsesRt = opcode 0x00, 0x04, 0x05, 0x28, 0x29 or 0x2B. Register 0 never causes a hazard. Shift instructions may stall conservatively.
- Branch classes: BR2 = opcode 0x04/0x05 (compare rs, rt). BR1 = opcode 0x01/0x06/0x07 (compare rs only).
- Load-use stall: MemRead_IDEX, RdAddr_IDEX != 0, and RdAddr_IDEX matches a used rs/rt.
- Branch stall:
  - BR1/BR2 in ID, RegWrite_IDEX, RdAddr_IDEX != 0, and RdAddr_IDEX matches a compared source.
  - Or MemRead_EXMEM, RdAddr_EXMEM != 0, and RdAddr_EXMEM matches a compared source.
  - A load followed by a dependent branch therefore stalls 2 cycles.
- HI/LO stall: MulDivBusy and ID holds opcode 0 with funct 0x10-0x13 or 0x18-0x1B.
- Stall = OR of the three stall terms, all combinational. When Stall: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0. Stall overrides flush because a branch outcome with stale operands is ignored.
- No stall: PCWrite=1, IFIDWrite=1, IDEXFlush=0, IFIDFlush = BranchTaken | Jump_ID.
- Mul/div FSM with states IDLE and BUSY, and counter cnt[CNT_W-1:0]:
  - IDLE: mult/multu (funct 0x18/0x19) or div/divu (0x1A/0x1B) in ID with no stall at a clock edge -> BUSY. cnt loads MUL_LAT or DIV_LAT, and MulDivStart=1 for the next cycle only.
  - BUSY: cnt decrements each cycle. When cnt goes 1->0, the FSM returns to IDLE and MulDivDone=1 for one cycle, registered in the cycle cnt==0.
  - MulDivBusy = (state==BUSY), registered.
  - Example: a mult leaves ID at edge E0. Busy is high for MUL_LAT cycles after E0. A dependent mflo held in ID issues in the cycle Done is high.
  - A new mul/div cannot start while BUSY because the HI/LO stall blocks it.
- StallCount increments on every edge where Stall=1 and rst_n=1, and saturates at 0xFFFF.
- Reset (rst_n=0 at an edge): state=IDLE, cnt=0, MulDivStart=0, MulDivBusy=0, MulDivDone=0, StallCount=0.
  - While rst_n=0, combinational outputs are forced to PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=1.
  - Reset in the middle of an operation aborts it with no Done pulse.

Test Plan:
- lw $2 in EX (MemRead_IDEX=1, RdAddr_IDEX=2); add $3,$2,$4 in ID -> one cycle of PCWrite=0, IFIDWrite=0, IDEXFlush=1; StallCount 0->1.
- lw $5 in EX, beq $5,$6 in ID, BranchTaken=1 -> 2 stall cycles with IFIDFlush=0 during them; third cycle IFIDFlush=1, PCWrite=1.
- addi $7 in EX (RegWrite_IDEX=1), bgtz $7 in ID -> 1 stall cycle. With RdAddr_IDEX=0 instead -> no stall.
- mult issued, mflo next in ID, MUL_LAT=4 -> MulDivStart pulse; 4 stall cycles; mflo issues in the cycle MulDivDone=1; MulDivBusy was high 4 cycles.
- div (DIV_LAT=32) issued; rst_n=0 at cycle 10 of BUSY -> Busy=0, no Done pulse, StallCount=0, PCWrite=0 during reset.
- Force a HI/LO stall for 70000 cycles -> StallCount holds 0xFFFF.
